i2c_slave_resp: RTL
===================

Name: i2c_slave_resp

Overview:
- I2C target (responder) for the team's I2C master driver, EEPROM-style.
- Runs oversampled on the system clock: detects START/STOP, matches its 7-bit device address, receives a 1- or 2-byte word address, then writes or reads bytes through a simple synchronous memory port.
- Used as a bus-side model of an on-chip register/EEPROM target, and as the loop-back partner for the master in simulation.

Parameters:
- SLAVE_ADDR, 7'b1010000, device address to match.
- ADDR_BYTES, 2, word-address bytes; legal values 1 or 2.

Ports:
- clk  input  1  system clock; at least 8x the SCL rate.
- rst_n  input  1  asynchronous, active-low reset.
- scl  input  1  I2C clock from the master.
- sda  inout  1  open-drain; driven 0 or released to high-Z, never driven 1.
- mem_addr  output  16  current word address.
- mem_wdata  output  8  received data byte.
- mem_we  output  1  one-clk write strobe.
- mem_re  output  1  one-clk read strobe.
- mem_rdata  input  8  read data, valid 1 clk after mem_re.
- busy  output  1  high from address match until STOP or mismatch.
- xfer_done  output  1  one-clk pulse on STOP ending an addressed transaction.

Behaviour:
- Reset values: sda released, mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0, busy=0, xfer_done=0, state IDLE.
- Input conditioning: scl and sda each pass a 2-flop synchronizer, then edge detection.
- Bus conditions, defined on synchronized signals:
  - START: sda falls while scl high.
  - STOP: sda rises while scl high.
- Bit timing: bits are sampled on scl rising edge. sda drive changes only on the clk following an scl falling edge.
- States: IDLE, DEV_ADDR, DEV_ACK, WADDR_HI, WADDR_LO, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- IDLE -> DEV_ADDR on START.
- DEV_ADDR: shift in 8 bits, MSB first.
  - Bits[7:1]==SLAVE_ADDR -> DEV_ACK, busy=1.
  - Otherwise -> IGNORE; no ACK, no memory activity.
- DEV_ACK: pull sda low from the falling edge after bit 8 to the falling edge after bit 9.
  - R/W=0 -> WADDR_HI if ADDR_BYTES=2, else WADDR_LO.
  - R/W=1 -> RD_DATA. Pulse mem_re on the clk after the bit-8 rising edge; load the shift register from mem_rdata 1 clk later.
- WADDR_HI / WADDR_LO: load mem_addr[15:8] / mem_addr[7:0], ACK after each byte. When ADDR_BYTES=1, mem_addr[15:8] is forced to 0. After the last address byte -> WR_DATA.
- WR_DATA: after 8 bits, mem_wdata=byte and mem_we pulses for 1 clk. Then WR_ACK (ACK driven), then mem_addr increments, then back to WR_DATA.
- RD_DATA: shift out MSB first. A 0 bit pulls sda low; a 1 bit releases it. After bit 8, release sda -> RD_ACK.
- RD_ACK: sample the master's bit on the scl rising edge.
  - ACK (0): increment mem_addr, pulse mem_re, reload the shift register, -> RD_DATA.
  - NACK (1): -> IGNORE.
- Word-address wrap: increment wraps 0xFFFF->0x0000. With ADDR_BYTES=1, 0x00FF->0x0000.
- START in any state: abort the current byte and go to DEV_ADDR. mem_addr is kept, so a repeated-start random read works.
- STOP in any state: release sda, go to IDLE, busy=0. xfer_done pulses if busy was 1.
- STOP mid-byte: partial byte discarded, no mem_we.
- IGNORE: sda released; leave only on START or STOP.
- rst_n asserted mid-transfer (including during ACK): sda released immediately (asynchronous), all state cleared.

Optional Feature:
- Macro I2C_GLITCH_FILTER_EN.
- Defined: after the synchronizers, each of scl and sda changes its filtered value only after 3 consecutive identical clk samples. This adds 2 clk of latency and rejects pulses shorter than 3 clk.
- Undefined: synchronized signals are used directly. Behaviour is otherwise identical.

Decomposition:
- Shared package i2c_pkg holds:
  - state encoding constants (one-hot, 11 states);
  - the default SLAVE_ADDR;
  - the R/W bit positions.
  The master driver reuses the same package.
- One sub-module, i2c_bus_cond: synchronizer, optional glitch filter, and outputs for scl_rise, scl_fall, start_det and stop_det.

Test Plan:
- Single write, ADDR_BYTES=2: START, 0xA0, 0x01, 0x23, 0xA5, STOP -> 4 ACKs (sda low on 9th clocks), exactly one mem_we with mem_addr=0x0123 and mem_wdata=0xA5, then one xfer_done.
- Random read: write address 0x0040, repeated START, 0xA1, mem_rdata=0x3C, master NACK, STOP -> mem_re with mem_addr=0x0040, sda bits 0,0,1,1,1,1,0,0, busy falls at STOP.
- Address mismatch 0xA2: 0xA2 followed by 2 bytes -> sda never driven, no mem_we/mem_re, busy stays 0, no xfer_done.
- Sequential write wrap: address 0xFFFF, data 0x11, 0x22, 0x33 -> mem_we at 0xFFFF, 0x0000, 0x0001 with those data values.
- STOP after 4 bits of a data byte -> IDLE, no mem_we; the next START with 0xA0 is ACKed normally.
- rst_n low while the target holds the ACK low -> sda high-Z within the same clk; after release, the bench sees IDLE and 0 on all outputs. With I2C_GLITCH_FILTER_EN, a 1-clk SCL pulse is ignored.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: one-hot state encoding, default device address,
// address-byte bit positions and the word-address increment helper.
package i2c_pkg;

    localparam int unsigned STATE_W = 11;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 11'h001,
        DEV_ADDR = 11'h002,
        DEV_ACK  = 11'h004,
        WADDR_HI = 11'h008,
        WADDR_LO = 11'h010,
        ADDR_ACK = 11'h020,
        WR_DATA  = 11'h040,
        WR_ACK   = 11'h080,
        RD_DATA  = 11'h100,
        RD_ACK   = 11'h200,
        IGNORE   = 11'h400
    } state_t;

    localparam logic [6:0]  DEFAULT_SLAVE_ADDR = 7'b1010000;

    // Layout of the first byte after START: {addr[6:0], rw}
    localparam int unsigned RW_BIT       = 0;
    localparam int unsigned DEV_ADDR_LSB = 1;
    localparam int unsigned DEV_ADDR_MSB = 7;

    // Word-address increment; one-byte addressing wraps within the low byte
    function automatic logic [15:0] next_word_addr(input logic [15:0] addr,
                                                   input int unsigned addr_bytes);
        logic [15:0] nxt;
        nxt = addr + 16'd1;
        if (addr_bytes == 1) nxt[15:8] = 8'h00;
        return nxt;
    endfunction

endpackage

// File: rtl/i2c_bus_cond.sv
// I2C bus conditioning: 2-flop synchronizers, optional glitch filter
// (I2C_GLITCH_FILTER_EN) and registered SCL-edge / START / STOP detection.
module i2c_bus_cond (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_bit
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_f;
    logic       sda_f;
    logic       scl_q;
    logic       sda_q;

    // Synchronizers; reset to the idle-bus level so no edge is seen at reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] scl_hist;
    logic [1:0] sda_hist;
    logic       scl_hold;
    logic       sda_hold;

    // Sample history and last accepted level of each line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_hold <= 1'b1;
            sda_hold <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
            scl_hold <= scl_f;
            sda_hold <= sda_f;
        end
    end

    // Accept a new level only after three consecutive identical samples
    always_comb begin
        scl_f = scl_hold;
        sda_f = sda_hold;
        if (scl_sync[1] == scl_hist[0] && scl_hist[0] == scl_hist[1]) scl_f = scl_sync[1];
        if (sda_sync[1] == sda_hist[0] && sda_hist[0] == sda_hist[1]) sda_f = sda_sync[1];
    end
`else
    assign scl_f = scl_sync[1];
    assign sda_f = sda_sync[1];
`endif

    // Edge and bus-condition detection; sda_bit is aligned with scl_rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_q     <= scl_f;
            sda_q     <= sda_f;
            scl_rise  <= scl_f & ~scl_q;
            scl_fall  <= ~scl_f & scl_q;
            start_det <= scl_f & scl_q & ~sda_f & sda_q;
            stop_det  <= scl_f & scl_q & sda_f & ~sda_q;
        end
    end

    assign sda_bit = sda_q;

endmodule

// File: rtl/i2c_slave_resp.sv
// EEPROM-style I2C target: device-address match, 1/2-byte word address,
// sequential write/read through a synchronous memory port.
// Optional build macro: I2C_GLITCH_FILTER_EN (see i2c_bus_cond).
module i2c_slave_resp
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR = DEFAULT_SLAVE_ADDR,
    parameter int unsigned ADDR_BYTES = 2   // 1 or 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl,
    inout  wire         sda,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    output logic        busy,
    output logic        xfer_done
);

    localparam int unsigned CNT_W = 4;

    logic             scl_rise;
    logic             scl_fall;
    logic             start_det;
    logic             stop_det;
    logic             sda_bit;
    logic             sda_oe;
    state_t           state;
    state_t           ack_next;
    logic [CNT_W-1:0] bit_cnt;
    logic [7:0]       shreg;
    logic [1:0]       rd_pend;
    logic [7:0]       rx_byte_c;

    // Open-drain driver: only ever pulls low
    assign sda = sda_oe ? 1'b0 : 1'bz;

    i2c_bus_cond u_bus_cond (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl       (scl),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_bit   (sda_bit)
    );

    assign rx_byte_c = {shreg[6:0], sda_bit};

    // Protocol FSM; in ACK states bit_cnt tracks 0=await fall, 1=driving, 2=after 9th rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ack_next  <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            rd_pend   <= '0;
            sda_oe    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            busy      <= 1'b0;
            xfer_done <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            xfer_done <= 1'b0;
            rd_pend   <= {rd_pend[0], 1'b0};
            // read data is valid one clk after the mem_re strobe
            if (rd_pend[1]) shreg <= mem_rdata;

            if (stop_det) begin
                state     <= IDLE;
                sda_oe    <= 1'b0;
                bit_cnt   <= '0;
                busy      <= 1'b0;
                xfer_done <= busy;
            end else if (start_det) begin
                state   <= DEV_ADDR;
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
            end else begin
                case (state)
                    DEV_ADDR, WADDR_HI, WADDR_LO, WR_DATA: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte_c;
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            if (bit_cnt == CNT_W'(7)) begin
                                bit_cnt <= '0;
                                if (state == DEV_ADDR) begin
                                    if (rx_byte_c[DEV_ADDR_MSB:DEV_ADDR_LSB] == SLAVE_ADDR) begin
                                        busy  <= 1'b1;
                                        state <= DEV_ACK;
                                        if (rx_byte_c[RW_BIT]) begin
                                            ack_next <= RD_DATA;
                                            mem_re   <= 1'b1;
                                            rd_pend  <= 2'b01;
                                        end else begin
                                            ack_next <= (ADDR_BYTES == 2) ? WADDR_HI : WADDR_LO;
                                        end
                                    end else begin
                                        busy  <= 1'b0;
                                        state <= IGNORE;
                                    end
                                end else if (state == WADDR_HI) begin
                                    mem_addr[15:8] <= rx_byte_c;
                                    ack_next       <= WADDR_LO;
                                    state          <= ADDR_ACK;
                                end else if (state == WADDR_LO) begin
                                    mem_addr[7:0] <= rx_byte_c;
                                    if (ADDR_BYTES == 1) mem_addr[15:8] <= 8'h00;
                                    ack_next      <= WR_DATA;
                                    state         <= ADDR_ACK;
                                end else begin
                                    mem_wdata <= rx_byte_c;
                                    mem_we    <= 1'b1;
                                    ack_next  <= WR_DATA;
                                    state     <= WR_ACK;
                                end
                            end
                        end
                    end
                    DEV_ACK, ADDR_ACK, WR_ACK: begin
                        if (scl_fall && bit_cnt == CNT_W'(0)) begin
                            sda_oe  <= 1'b1;
                            bit_cnt <= CNT_W'(1);
                        end else if (scl_rise && bit_cnt == CNT_W'(1)) begin
                            bit_cnt <= CNT_W'(2);
                        end else if (scl_fall && bit_cnt == CNT_W'(2)) begin
                            bit_cnt <= '0;
                            state   <= ack_next;
                            // a read starts driving its MSB in the same low phase
                            sda_oe  <= (ack_next == RD_DATA) ? ~shreg[7] : 1'b0;
                            if (state == WR_ACK) mem_addr <= next_word_addr(mem_addr, ADDR_BYTES);
                        end
                    end
                    RD_DATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end else if (scl_fall) begin
                            if (bit_cnt == CNT_W'(8)) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= RD_ACK;
                            end else begin
                                shreg  <= {shreg[6:0], 1'b0};
                                sda_oe <= ~shreg[6];
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise && bit_cnt == CNT_W'(0)) begin
                            if (!sda_bit) begin
                                mem_addr <= next_word_addr(mem_addr, ADDR_BYTES);
                                mem_re   <= 1'b1;
                                rd_pend  <= 2'b01;
                                bit_cnt  <= CNT_W'(1);
                            end else begin
                                state <= IGNORE;
                            end
                        end else if (scl_fall && bit_cnt == CNT_W'(1)) begin
                            sda_oe  <= ~shreg[7];
                            bit_cnt <= '0;
                            state   <= RD_DATA;
                        end
                    end
                    IDLE, IGNORE: begin
                    end
                    default: begin
                        state  <= IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
